// File: rtl/ecall_handler.sv
// rtl/ecall_handler.sv - ECALL service handler: print/read/exit services with debounced confirm button
//
// Ports:
//   clk_23     in   1   system clock, all state changes on rising edge
//   rst_n      in   1   synchronous active-low reset
//   ecall      in   1   level request, high while the core is stalled on ECALL
//   a7         in  32   service number (latched when the request is accepted)
//   a0         in  32   service argument (latched when the request is accepted)
//   switches   in  16   board switches, sampled at the accepted press of a read service
//   confirm    in   1   raw confirm push-button
//   finish     out  1   one-cycle pulse releasing the core
//   wb_en      out  1   one-cycle a0 write strobe, coincident with finish
//   wb_data    out 32   a0 writeback value
//   seg_value  out 32   seven-segment display value
//   led        out 16   LED outputs
//   halted     out  1   sticky exit indication
//   busy       out  1   high while a service is in progress
module ecall_handler #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk_23,
    input  logic        rst_n,
    input  logic        ecall,
    input  logic [31:0] a7,
    input  logic [31:0] a0,
    input  logic [15:0] switches,
    input  logic        confirm,
    output logic        finish,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] seg_value,
    output logic [15:0] led,
    output logic        halted,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_READ_INT   = 32'd5;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT_RELEASE,
        S_WAIT_PRESS,
        S_DONE,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   svc_q;
    logic [31:0]   arg_q;
    logic [CW-1:0] db_cnt;
    logic          pressed;

    assign pressed = (db_cnt == DB_MAX);

    // Saturating run-length counter of consecutive high confirm samples.
    always_ff @(posedge clk_23) begin
        if (!rst_n) begin
            db_cnt <= '0;
        end else if (!confirm) begin
            db_cnt <= '0;
        end else if (!pressed) begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_23) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        wb_en    = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (ecall) begin
                    state_nx = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                case (svc_q)
                    SVC_PRINT_INT,
                    SVC_READ_INT:   state_nx = S_WAIT_RELEASE;
                    SVC_EXIT:       state_nx = S_HALT;
                    default:        state_nx = S_DONE;
                endcase
            end
            // A button still held from an earlier service must be let go first.
            S_WAIT_RELEASE: begin
                if (!pressed) begin
                    state_nx = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                if (pressed) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                finish   = 1'b1;
                wb_en    = (svc_q == SVC_READ_INT);
                state_nx = S_DRAIN;
            end
            // Hold off until the core drops ecall so one request yields one finish.
            S_DRAIN: begin
                if (!ecall) begin
                    state_nx = S_IDLE;
                end
            end
            S_HALT: begin
                busy = 1'b0;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_23) begin
        if (!rst_n) begin
            svc_q     <= '0;
            arg_q     <= '0;
            wb_data   <= '0;
            seg_value <= '0;
            led       <= '0;
            halted    <= 1'b0;
        end else begin
            if (state == S_IDLE && ecall) begin
                svc_q <= a7;
                arg_q <= a0;
            end
            if (state == S_DISPATCH) begin
                if (svc_q == SVC_PRINT_INT) begin
                    seg_value <= arg_q;
                end
                if (svc_q == SVC_PRINT_CHAR) begin
                    led <= {8'h00, arg_q[7:0]};
                end
                if (svc_q == SVC_EXIT) begin
                    halted <= 1'b1;
                end
            end
            // Read value is captured on the accepted press so it is stable in DONE.
            if (state == S_WAIT_PRESS && pressed && svc_q == SVC_READ_INT) begin
                wb_data   <= {{16{switches[15]}}, switches};
                seg_value <= {{16{switches[15]}}, switches};
            end
        end
    end

endmodule

// File: tb/tb_ecall_handler.sv
// tb/tb_ecall_handler.sv - self-checking bench for ecall_handler
module tb_ecall_handler;

    localparam int DB = 16;

    logic        clk_23 = 1'b0;
    logic        rst_n;
    logic        ecall;
    logic [31:0] a7;
    logic [31:0] a0;
    logic [15:0] switches;
    logic        confirm;
    logic        finish;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [31:0] seg_value;
    logic [15:0] led;
    logic        halted;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] exp_seg;
    logic [31:0] exp_wb;
    logic [15:0] exp_led;
    logic        conf [200];

    ecall_handler #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk_23    (clk_23),
        .rst_n     (rst_n),
        .ecall     (ecall),
        .a7        (a7),
        .a0        (a0),
        .switches  (switches),
        .confirm   (confirm),
        .finish    (finish),
        .wb_en     (wb_en),
        .wb_data   (wb_data),
        .seg_value (seg_value),
        .led       (led),
        .halted    (halted),
        .busy      (busy)
    );

    always #5 clk_23 = ~clk_23;

    typedef struct {
        logic        rst_n;
        logic        ecall;
        logic [31:0] a7;
        logic [31:0] a0;
        logic        exp_finish;
        logic        exp_busy;
        logic [15:0] exp_led;
    } vec_t;

    vec_t tbl [18];

    task automatic tick();
        @(posedge clk_23);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Length of the high run of confirm seen before relative cycle t, capped at DB.
    function automatic int cnt_at(input int t, input logic pre);
        int run;
        int k;
        run = 0;
        k = t - 1;
        while (k >= 0 && conf[k]) begin
            run++;
            k--;
        end
        if (k < 0 && pre) run += 20;
        return (run > DB) ? DB : run;
    endfunction

    // Relative cycle of the finish pulse for a request rising at cycle 0.
    function automatic int model_finish(input logic [31:0] s, input logic pre);
        int r;
        if (s != 32'd1 && s != 32'd5) return 2;
        r = -1;
        for (int t = 2; t < 200; t++) begin
            if (cnt_at(t, pre) < DB) begin
                r = t;
                break;
            end
        end
        if (r < 0) return -1;
        for (int t = r + 1; t < 200; t++) begin
            if (cnt_at(t, pre) == DB) return t + 1;
        end
        return -1;
    endfunction

    task automatic run_service(input logic [31:0] sa7, input logic [31:0] sa0,
                               input logic [15:0] sw, input logic pre, input bit noise);
        int f;
        f = model_finish(sa7, pre);
        if (f < 0) begin
            nchk++;
            nerr++;
            $display("FAIL model_budget: got no finish expected finish within 200 cycles");
            return;
        end
        switches = sw;
        confirm  = pre;
        ecall    = 1'b0;
        repeat (20) tick();
        if (sa7 == 32'd1) exp_seg = sa0;
        if (sa7 == 32'd5) begin
            exp_wb  = {{16{sw[15]}}, sw};
            exp_seg = exp_wb;
        end
        if (sa7 == 32'd11) exp_led = {8'h00, sa0[7:0]};
        for (int t = 0; t <= f + 2; t++) begin
            ecall   = (t <= f);
            confirm = (t < 200) ? conf[t] : 1'b0;
            if (t == 0) begin
                a7 = sa7;
                a0 = sa0;
            end else if (noise) begin
                a7 = $urandom_range(0, 12);
                a0 = $urandom;
            end
            chk("finish", finish, (t == f));
            chk("wb_en", wb_en, (t == f && sa7 == 32'd5));
            chk("busy", busy, (t >= 1 && t <= f + 1));
            if (t == 2 && sa7 == 32'd1) chk("seg_after_dispatch", seg_value, sa0);
            if (t == f) begin
                chk("seg_value", seg_value, exp_seg);
                chk("led", led, exp_led);
                chk("wb_data", wb_data, exp_wb);
            end
            tick();
        end
    endtask

    initial begin
        int fcount;
        int len;
        logic lvl;
        logic [31:0] s;

        rst_n = 1'b0; ecall = 1'b0; a7 = '0; a0 = '0; switches = '0; confirm = 1'b0;
        exp_seg = '0; exp_wb = '0; exp_led = '0;
        repeat (2) tick();
        chk("rst_finish", finish, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_seg", seg_value, 0);
        chk("rst_led", led, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", busy, 0);

        // Print char and unsupported services: fast path, latching, drain behaviour.
        tbl[0]  = '{1'b1, 1'b1, 32'd11, 32'h141,      1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 32'd99, 32'h0,        1'b0, 1'b1, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 32'd5,  32'h0,        1'b1, 1'b1, 16'h0041};
        tbl[3]  = '{1'b1, 1'b1, 32'd1,  32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[4]  = '{1'b1, 1'b0, 32'd99, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[5]  = '{1'b1, 1'b1, 32'd99, 32'h0,        1'b0, 1'b0, 16'h0041};
        tbl[6]  = '{1'b1, 1'b1, 32'd1,  32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[7]  = '{1'b1, 1'b1, 32'd11, 32'h0,        1'b1, 1'b1, 16'h0041};
        tbl[8]  = '{1'b1, 1'b1, 32'd11, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[9]  = '{1'b1, 1'b1, 32'd11, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[10] = '{1'b1, 1'b1, 32'd11, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[11] = '{1'b1, 1'b1, 32'd11, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[12] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[13] = '{1'b1, 1'b1, 32'd11, 32'hABCD1234, 1'b0, 1'b0, 16'h0041};
        tbl[14] = '{1'b1, 1'b1, 32'd99, 32'h0,        1'b0, 1'b1, 16'h0041};
        tbl[15] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b1, 1'b1, 16'h0034};
        tbl[16] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b1, 16'h0034};
        tbl[17] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, 1'b0, 16'h0034};
        for (int i = 0; i < 18; i++) begin
            rst_n = tbl[i].rst_n;
            ecall = tbl[i].ecall;
            a7    = tbl[i].a7;
            a0    = tbl[i].a0;
            chk("tbl_finish", finish, tbl[i].exp_finish);
            chk("tbl_wb_en", wb_en, 0);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            chk("tbl_led", led, tbl[i].exp_led);
            chk("tbl_halted", halted, 0);
            tick();
        end
        exp_led = 16'h0034;

        // Print int: 3-cycle glitch then 16 stable cycles.
        for (int t = 0; t < 200; t++) conf[t] = (t >= 3 && t <= 5) || (t >= 7 && t <= 22);
        run_service(32'd1, 32'h0000002A, 16'h0, 1'b0, 1'b0);

        // Read int with the button already held at the request.
        for (int t = 0; t < 200; t++) conf[t] = (t <= 9) || (t >= 12 && t <= 27);
        run_service(32'd5, 32'h0, 16'h8001, 1'b1, 1'b0);

        // Randomized services with random button bounce.
        for (int n = 0; n < 30; n++) begin
            int t;
            t = 0;
            lvl = 1'($urandom_range(0, 1));
            while (t < 100) begin
                len = $urandom_range(1, 12);
                for (int k = 0; k < len && t < 100; k++) begin
                    conf[t] = lvl;
                    t++;
                end
                lvl = ~lvl;
            end
            conf[100] = 1'b0;
            conf[101] = 1'b0;
            for (int k = 102; k < 200; k++) conf[k] = 1'b1;
            case ($urandom_range(0, 3))
                0:       s = 32'd1;
                1:       s = 32'd5;
                2:       s = 32'd11;
                default: s = $urandom_range(12, 1000);
            endcase
            run_service(s, $urandom, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset in the middle of a read service.
        confirm = 1'b0; ecall = 1'b0;
        repeat (20) tick();
        ecall = 1'b1; a7 = 32'd5; a0 = 32'h0; switches = 16'h1234;
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        confirm = 1'b1;
        fcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (finish || wb_en) fcount++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ecall = 1'b0;
        chk("mid_rst_finish", finish, 0);
        chk("mid_rst_wb_en", wb_en, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        chk("mid_rst_seg", seg_value, 0);
        chk("mid_rst_led", led, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            if (finish || wb_en) fcount++;
            tick();
        end
        chk("mid_rst_no_finish", fcount, 0);
        confirm = 1'b0;

        // Exit service and recovery by reset.
        repeat (3) tick();
        ecall = 1'b1; a7 = 32'd10; a0 = 32'h0;
        repeat (2) tick();
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        fcount = 0;
        for (int i = 0; i < 100; i++) begin
            confirm = ((i % 40) < 25) ? 1'b1 : 1'($urandom_range(0, 1));
            ecall   = 1'($urandom_range(0, 1));
            if (finish || wb_en || busy) fcount++;
            tick();
        end
        chk("halt_no_finish", fcount, 0);
        chk("halt_sticky", halted, 1);
        confirm = 1'b0;
        rst_n = 1'b0; ecall = 1'b1; a7 = 32'd11; a0 = 32'h55;
        tick();
        rst_n = 1'b1;
        chk("post_halt_halted", halted, 0);
        chk("post_halt_busy", busy, 0);
        tick();
        chk("rerequest_busy", busy, 1);
        tick();
        chk("rerequest_finish", finish, 1);
        chk("rerequest_led", led, 16'h0055);
        ecall = 1'b0;
        repeat (2) tick();
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
